// File: rtl/cla_pipelined_adder.sv
// -----------------------------------------------------------------------------
// cla_pipelined_adder
//
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is cut
// into STAGES equal slices. Each slice is a block CLA built from 4-bit groups
// plus a lookahead carry unit. The slice carry-out is registered into the next
// slice. Upper operand slices are skewed forward and finished result slices
// are deskewed forward, so one beat per cycle flows through with latency
// STAGES. A valid/ready handshake stalls the whole pipe as one unit.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid          in_ready   beat accepted this cycle
//   a, b       operands (WIDTH)            cin        carry-in / borrow-in
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid                out_ready  consumer takes result
//   sum        result (mod 2^WIDTH)        cout       carry out (NOT borrow)
//   ovf        signed overflow             zero       sum == 0
//   p_all      full-width block propagate  g_all      full-width block generate
//
// WIDTH must be a multiple of 4*STAGES; GROUP must be 4.
// -----------------------------------------------------------------------------
module cla_pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             p_all,
  output logic             g_all
);

  localparam int SW = WIDTH / STAGES;  // slice width
  localparam int NG = SW / GROUP;      // 4-bit CLA groups per slice

  // One slice of block CLA. Returns {G, P, carry_out, sum[SW-1:0]}.
  // G/P describe the slice alone (independent of ci).
  function automatic logic [SW+2:0] slice_cla(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW-1:0] s;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic [3:0]    gpv;
    logic [3:0]    ggv;
    logic [3:0]    c;
    logic          t;
    logic          pp;
    p  = x ^ y;
    g  = x & y;
    gp = '0;
    gg = '0;
    s  = '0;
    // Group propagate / generate.
    for (int j = 0; j < NG; j++) begin
      gpv   = p[j*4 +: 4];
      ggv   = g[j*4 +: 4];
      gp[j] = &gpv;
      gg[j] = ggv[3] | (gpv[3] & ggv[2]) | (gpv[3] & gpv[2] & ggv[1]) |
              (gpv[3] & gpv[2] & gpv[1] & ggv[0]);
    end
    // Lookahead carry unit: each group carry-in as a sum of products of the
    // group P/G terms, so no carry ripples between groups.
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      t  = 1'b0;
      pp = 1'b1;
      for (int i = j; i >= 0; i--) begin
        t  = t | (gg[i] & pp);
        pp = pp & gp[i];
      end
      gc[j+1] = t | (pp & ci);
    end
    // In-group carries and sum bits.
    for (int j = 0; j < NG; j++) begin
      gpv  = p[j*4 +: 4];
      ggv  = g[j*4 +: 4];
      c[0] = gc[j];
      c[1] = ggv[0] | (gpv[0] & gc[j]);
      c[2] = ggv[1] | (gpv[1] & ggv[0]) | (gpv[1] & gpv[0] & gc[j]);
      c[3] = ggv[2] | (gpv[2] & ggv[1]) | (gpv[2] & gpv[1] & ggv[0]) |
             (gpv[2] & gpv[1] & gpv[0] & gc[j]);
      s[j*4 +: 4] = gpv ^ c;
    end
    // Slice generate, without the carry-in.
    t  = 1'b0;
    pp = 1'b1;
    for (int i = NG - 1; i >= 0; i--) begin
      t  = t | (gg[i] & pp);
      pp = pp & gp[i];
    end
    return {t, &gp, gc[NG], s};
  endfunction

  logic             en;
  logic [WIDTH-1:0] beff;
  logic             ceff;

  // Subtraction as a + ~b + ~cin; cout is then the inverted borrow.
  assign beff     = sub ? ~b : b;
  assign ceff     = sub ? ~cin : cin;
  // The whole pipe advances together; a full output that is not taken freezes it.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [SW-1:0]         a_s;
    logic [SW-1:0]         b_s;
    logic                  c_s;
    logic                  v_s;
    logic [SW+2:0]         cla_w;
    logic [SW-1:0]         s_w;
    logic                  co_w;
    logic                  p_w;
    logic                  g_w;
    logic [(gi+1)*SW-1:0]  res_d;
    logic [(gi+1)*SW-1:0]  res_q;
    logic [gi:0]           p_d;
    logic [gi:0]           g_d;
    logic                  c_q;
    logic                  v_q;

    assign cla_w = slice_cla(a_s, b_s, c_s);
    assign s_w   = cla_w[SW-1:0];
    assign co_w  = cla_w[SW];
    assign p_w   = cla_w[SW+1];
    assign g_w   = cla_w[SW+2];

    if (gi == 0) begin : g_head
      assign a_s   = a[SW-1:0];
      assign b_s   = beff[SW-1:0];
      assign c_s   = ceff;
      assign v_s   = in_valid;
      assign res_d = s_w;
      assign p_d   = p_w;
      assign g_d   = g_w;
    end else begin : g_body
      assign a_s   = g_stage[gi-1].g_fwd.a_up_q[SW-1:0];
      assign b_s   = g_stage[gi-1].g_fwd.b_up_q[SW-1:0];
      assign c_s   = g_stage[gi-1].c_q;
      assign v_s   = g_stage[gi-1].v_q;
      // Lower result slices ride along so all bits leave together.
      assign res_d = {s_w, g_stage[gi-1].res_q};
      assign p_d   = {p_w, g_stage[gi-1].g_fwd.p_q};
      assign g_d   = {g_w, g_stage[gi-1].g_fwd.g_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (en) begin
        v_q   <= v_s;
        c_q   <= co_w;
        res_q <= res_d;
      end
    end

    // Operand skew and slice P/G history for the stages still to come.
    if (gi < STAGES - 1) begin : g_fwd
      localparam int UW = WIDTH - (gi + 1) * SW;
      logic [UW-1:0] a_up_d;
      logic [UW-1:0] b_up_d;
      logic [UW-1:0] a_up_q;
      logic [UW-1:0] b_up_q;
      logic [gi:0]   p_q;
      logic [gi:0]   g_q;

      if (gi == 0) begin : g_src_in
        assign a_up_d = a[WIDTH-1:SW];
        assign b_up_d = beff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign a_up_d = g_stage[gi-1].g_fwd.a_up_q[UW+SW-1:SW];
        assign b_up_d = g_stage[gi-1].g_fwd.b_up_q[UW+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
          p_q    <= '0;
          g_q    <= '0;
        end else if (en) begin
          a_up_q <= a_up_d;
          b_up_q <= b_up_d;
          p_q    <= p_d;
          g_q    <= g_d;
        end
      end
    end

    // Last slice: flags are formed here and registered alongside the sum.
    if (gi == STAGES - 1) begin : g_tail
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;
      logic pall_d;
      logic pall_q;
      logic gall_d;
      logic gall_q;

      // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c.
      assign ovf_d  = (s_w[SW-1] ^ a_s[SW-1] ^ b_s[SW-1]) ^ co_w;
      assign zero_d = ~|res_d;
      assign pall_d = &p_d;

      always_comb begin
        gall_d = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
          gall_d = g_d[i] | (p_d[i] & gall_d);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          pall_q <= 1'b0;
          gall_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
          pall_q <= pall_d;
          gall_q <= gall_d;
        end
      end

      assign out_valid = v_q;
      assign sum       = res_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
      assign zero      = zero_q;
      assign p_all     = pall_q;
      assign g_all     = gall_q;
    end
  end

endmodule

// File: doc/cla_pipelined_adder.md
Name: cla_pipelined_adder

Overview:
- Parametrised, pipelined successor to the 16-bit block-CLA adder.
- Splits a WIDTH-bit add/subtract into STAGES equal slices. Each slice is built from 4-bit CLA groups and a lookahead carry unit; the slice carry-out is registered into the next slice.
- Operands and results are skewed and deskewed so that one operation per cycle flows through with fixed latency.
- Serves as the ALU adder path of the miniRISC datapath and for address and branch-target computation; a valid/ready handshake allows back-pressure.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4*STAGES.
- STAGES, 2, number of pipeline slices (1..8); the latency equals STAGES.
- GROUP, 4, CLA group width inside a slice; fixed at 4; other values are illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: sum=a+b+cin; 1: sum=a-b-cin.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (add); NOT borrow (sub).
- ovf  out  1  signed overflow.
- zero  out  1  sum==0.
- p_all  out  1  block propagate of the full WIDTH (AND of all slice P).
- g_all  out  1  block generate of the full WIDTH (from the lookahead over slice P/G, without cin).

Behaviour:
- Reset (rst_n=0, async): all stage valid bits, sum, cout, ovf, zero, p_all and g_all are 0; out_valid is 0. in_ready is 1 once rst_n is released. Reset mid-operation discards every in-flight beat; no partial result ever appears.
- Preprocessing at accept:
  - beff = sub ? ~b : b
  - ceff = sub ? ~cin : cin
- Advance enable: en = out_ready | ~out_valid. in_ready = en.
  - All pipeline registers, including the valid bits, load only when en=1. The whole pipe stalls as a unit; interior bubbles are not collapsed.
- Accept rule: a beat is accepted when in_valid & in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1) handles bits [(k+1)*W/S-1 : k*W/S]:
  - Combinational CLA of the slice, with a carry-in equal to ceff for k=0 or the registered carry of stage k-1.
  - Registers: the slice sum, the slice carry-out, slice P/G, the valid bit, and the not-yet-used upper operand slices (input skew).
  - Lower result slices ride forward in a deskew shift register, so all WIDTH result bits emerge together.
- Latency: exactly STAGES cycles from accept to out_valid, when there is no stall.
- Throughput: 1 beat per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum, cout, ovf, zero, p_all and g_all hold stable and in_ready=0.
- Flags are computed in the last stage and registered with sum:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = ~|sum.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via cout.
- Simultaneous events: with out_valid=1 and out_ready=1 and in_valid=1 in the same cycle, the output retires and the new beat is accepted in that same cycle.
- STAGES=1: a single registered CLA with latency 1.

Test Plan:
- Reset/idle, WIDTH=32, STAGES=2: assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 and sum=0 immediately. Release -> in_ready=1 and no stale beat emerges.
- Add with carry across a slice boundary: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 -> 2 cycles later sum=0x00010000, cout=0, ovf=0, zero=0.
- Full wrap:
  - a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0, cout=1, zero=1, p_all=1, g_all=0.
  - a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0 (borrow).
  - a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
- Streaming plus back-pressure: 8 back-to-back beats (a=i, b=i<<16), with out_ready low for 3 cycles after the 2nd result -> results in order with no loss or duplication, outputs stable while stalled, and in_ready low exactly while stalled.
- Parameter sweep: STAGES in {1,2,4,8} with WIDTH=32 and WIDTH=64, random operands and modes vs a reference model -> results match, and latency equals STAGES.
